// File: rtl/set_ctrl.sv
// Set controller for a 4-way set-associative cache: hit detection,
// LRU replacement, write-back and line fill sequencing.
module set_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  output logic        cpu_hit,
  input  logic [3:0]  valid,
  input  logic [3:0]  dirty,
  input  logic [75:0] tag_in,
  output logic [3:0]  en,
  output logic        en_change,
  output logic        en_alloc,
  output logic [18:0] tag,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [18:0]       tag_q, tag_d;
  logic [6:0]        idx_q, idx_d;
  logic              we_q, we_d;
  logic              hit_q, hit_d;
  logic [1:0]        victim_q, victim_d;
  logic [18:0]       wb_tag_q, wb_tag_d;
  logic [3:0][1:0]   age_q, age_d;

  logic [3:0][18:0]  way_tag;
  logic [3:0]        hit_vec;
  logic              any_hit;
  logic [1:0]        hit_way;
  logic [1:0]        victim_sel;

  assign way_tag = tag_in;
  assign tag     = tag_q;

  // Every age below the touched way's age moves up by one.
  function automatic logic [3:0][1:0] lru_touch(
    input logic [3:0][1:0] a,
    input logic [1:0]      w
  );
    logic [3:0][1:0] r;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(w))
        r[i] = 2'd0;
      else if (a[i] < a[w])
        r[i] = a[i] + 2'd1;
      else
        r[i] = a[i];
    end
    return r;
  endfunction

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < 4; i++)
      hit_vec[i] = valid[i] && (way_tag[i] == tag_q);
  end

  assign any_hit = |hit_vec;

  always_comb begin
    hit_way = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (hit_vec[i]) hit_way = 2'(i);
  end

  // Free ways are preferred; otherwise evict the oldest.
  always_comb begin
    victim_sel = 2'd0;
    if (&valid) begin
      for (int i = 0; i < 4; i++)
        if (age_q[i] == 2'd3) victim_sel = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (!valid[i]) victim_sel = 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    we_d      = we_q;
    hit_d     = hit_q;
    victim_d  = victim_q;
    wb_tag_d  = wb_tag_q;
    age_d     = age_q;
    cpu_ready = 1'b0;
    cpu_hit   = 1'b0;
    en        = 4'b0000;
    en_change = 1'b0;
    en_alloc  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          tag_d   = cpu_addr[31:13];
          idx_d   = cpu_addr[12:6];
          we_d    = cpu_we;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (any_hit) begin
          hit_d = 1'b1;
          age_d = lru_touch(age_q, hit_way);
          if (we_q) begin
            en        = 4'b0001 << hit_way;
            en_change = 1'b1;
          end
          state_d = DONE;
        end else begin
          hit_d    = 1'b0;
          victim_d = victim_sel;
          wb_tag_d = way_tag[victim_sel];
          if (valid[victim_sel] && dirty[victim_sel])
            state_d = WRITEBACK;
          else
            state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {wb_tag_q, idx_q, 6'b0};
        if (mem_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, idx_q, 6'b0};
        if (mem_ack) begin
          en        = 4'b0001 << victim_q;
          en_alloc  = 1'b1;
          en_change = we_q;
          age_d     = lru_touch(age_q, victim_q);
          state_d   = DONE;
        end
      end
      DONE: begin
        cpu_ready = 1'b1;
        cpu_hit   = hit_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      hit_q    <= 1'b0;
      victim_q <= '0;
      wb_tag_q <= '0;
      age_q    <= {2'd3, 2'd2, 2'd1, 2'd0};
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
      wb_tag_q <= wb_tag_d;
      age_q    <= age_d;
    end
  end

endmodule

// File: tb/tb_set_ctrl.sv
// Directed bench for set_ctrl: miss/fill, write hit, write-back,
// stalled ack, async reset, LRU ordering and multi-hit priority.
module tb_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_hit;
  logic [3:0]  valid;
  logic [3:0]  dirty;
  logic [75:0] tag_in;
  logic [3:0]  en;
  logic        en_change;
  logic        en_alloc;
  logic [18:0] tag;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  set_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_hit   (cpu_hit),
    .valid     (valid),
    .dirty     (dirty),
    .tag_in    (tag_in),
    .en        (en),
    .en_change (en_change),
    .en_alloc  (en_alloc),
    .tag       (tag),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic w);
    step();
    cpu_req  = 1'b1;
    cpu_addr = a;
    cpu_we   = w;
    step();
    cpu_req  = 1'b0;
    #1;
  endtask

  task automatic set_tags(
    input logic [18:0] t0, input logic [18:0] t1,
    input logic [18:0] t2, input logic [18:0] t3
  );
    tag_in = {t3, t2, t1, t0};
  endtask

  // Read hit sequence: COMPARE, then DONE with hit.
  task automatic read_hit(input string nm, input logic [31:0] a);
    issue(a, 1'b0);
    chk({nm, "_cmp_en"}, 32'(en), 32'h0);
    step(); #1;
    chk({nm, "_rdy"}, 32'(cpu_ready), 32'h1);
    chk({nm, "_hit"}, 32'(cpu_hit), 32'h1);
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    valid = '0; dirty = '0; tag_in = '0; mem_ack = 1'b0;
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_memreq", 32'(mem_req), 32'h0);
    chk("rst_memaddr", mem_addr, 32'h0);
    chk("rst_tag", 32'(tag), 32'h0);
    chk("rst_en", {28'h0, en}, 32'h0);
    step();
    rst = 1'b1;

    // Cold read miss into way 0.
    issue(32'h0000_2040, 1'b0);
    chk("t1_cmp_ready", 32'(cpu_ready), 32'h0);
    chk("t1_cmp_memreq", 32'(mem_req), 32'h0);
    step(); #1;
    chk("t1_alloc_req", 32'(mem_req), 32'h1);
    chk("t1_alloc_we", 32'(mem_we), 32'h0);
    chk("t1_alloc_addr", mem_addr, 32'h0000_2040);
    chk("t1_alloc_en0", 32'(en), 32'h0);
    mem_ack = 1'b1; #1;
    chk("t1_ack_en", 32'(en), 32'h1);
    chk("t1_ack_alloc", 32'(en_alloc), 32'h1);
    chk("t1_ack_chg", 32'(en_change), 32'h0);
    chk("t1_tag", 32'(tag), 32'h1);
    step(); mem_ack = 1'b0; #1;
    chk("t1_ready", 32'(cpu_ready), 32'h1);
    chk("t1_hit", 32'(cpu_hit), 32'h0);
    step(); #1;
    chk("t1_idle_ready", 32'(cpu_ready), 32'h0);

    // Write hit on way 0.
    valid = 4'b0001;
    set_tags(19'h1, 19'h0, 19'h0, 19'h0);
    issue(32'h0000_2044, 1'b1);
    chk("t2_en", 32'(en), 32'h1);
    chk("t2_chg", 32'(en_change), 32'h1);
    chk("t2_memreq", 32'(mem_req), 32'h0);
    step(); #1;
    chk("t2_ready", 32'(cpu_ready), 32'h1);
    chk("t2_hit", 32'(cpu_hit), 32'h1);
    chk("t2_en_done", 32'(en), 32'h0);
    chk("t2_memreq2", 32'(mem_req), 32'h0);

    // Dirty eviction of way 3 (age 3), then a stalled fill.
    valid = 4'b1111;
    dirty = 4'b1000;
    set_tags(19'h1, 19'h2, 19'h3, 19'h7FFFF);
    issue(32'h2468_A140, 1'b0);
    chk("t3_cmp_en", 32'(en), 32'h0);
    step(); #1;
    chk("t3_wb_req", 32'(mem_req), 32'h1);
    chk("t3_wb_we", 32'(mem_we), 32'h1);
    chk("t3_wb_addr", mem_addr, 32'hFFFF_E140);
    step(); #1;
    chk("t3_wb_hold", mem_addr, 32'hFFFF_E140);
    mem_ack = 1'b1; #1;
    chk("t3_wb_en", 32'(en), 32'h0);
    step(); mem_ack = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_wait_req", 32'(mem_req), 32'h1);
      chk("t3_wait_we", 32'(mem_we), 32'h0);
      chk("t3_wait_addr", mem_addr, 32'h2468_A140);
      chk("t3_wait_en", 32'(en), 32'h0);
      step();
    end
    cpu_req = 1'b0;
    mem_ack = 1'b1; #1;
    chk("t3_ack_en", 32'(en), 32'h8);
    chk("t3_ack_alloc", 32'(en_alloc), 32'h1);
    chk("t3_ack_tag", 32'(tag), 32'h12345);
    step(); mem_ack = 1'b0; #1;
    chk("t3_ready", 32'(cpu_ready), 32'h1);
    chk("t3_hit", 32'(cpu_hit), 32'h0);
    step(); #1;
    chk("t3_no_restart", 32'(mem_req), 32'h0);

    // Reset in the middle of a write-back (ages now 1,2,3,0 -> way 2).
    dirty = 4'b1111;
    set_tags(19'h11, 19'h22, 19'h33, 19'h44);
    issue({19'h55, 7'd3, 6'd0}, 1'b0);
    step(); #1;
    chk("t4_wb_req", 32'(mem_req), 32'h1);
    chk("t4_wb_addr", mem_addr, {19'h33, 7'd3, 6'd0});
    #1 rst = 1'b0; #1;
    chk("t4_rst_req", 32'(mem_req), 32'h0);
    chk("t4_rst_ready", 32'(cpu_ready), 32'h0);
    step(); rst = 1'b1;
    step(); #1;
    chk("t4_post_ready", 32'(cpu_ready), 32'h0);
    chk("t4_post_tag", 32'(tag), 32'h0);
    read_hit("t4_rerun", {19'h11, 7'd2, 6'd0});

    // Hits on ways 0..3 leave way 0 oldest.
    read_hit("t5_w0", {19'h11, 7'd4, 6'd0});
    read_hit("t5_w1", {19'h22, 7'd4, 6'd0});
    read_hit("t5_w2", {19'h33, 7'd4, 6'd0});
    read_hit("t5_w3", {19'h44, 7'd4, 6'd0});
    dirty = 4'b0000;
    issue({19'h66, 7'd4, 6'd0}, 1'b1);
    step(); #1;
    chk("t5_miss_we", 32'(mem_we), 32'h0);
    chk("t5_miss_addr", mem_addr, 32'h000C_C100);
    mem_ack = 1'b1; #1;
    chk("t5_miss_en", 32'(en), 32'h1);
    chk("t5_miss_chg", 32'(en_change), 32'h1);
    step(); mem_ack = 1'b0; #1;
    chk("t5_ready", 32'(cpu_ready), 32'h1);

    // Two ways match: the lower index is enabled.
    set_tags(19'h11, 19'h77, 19'h33, 19'h77);
    issue({19'h77, 7'd9, 6'd0}, 1'b1);
    chk("t6_en", 32'(en), 32'h2);
    chk("t6_chg", 32'(en_change), 32'h1);
    step(); #1;
    chk("t6_hit", 32'(cpu_hit), 32'h1);

    // Ack outside a memory state is ignored.
    step();
    mem_ack = 1'b1; #1;
    chk("t7_stray_en", 32'(en), 32'h0);
    chk("t7_stray_alloc", 32'(en_alloc), 32'h0);
    step(); mem_ack = 1'b0; #1;
    chk("t7_stray_ready", 32'(cpu_ready), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
